ex_div: RTL and testbench

Iterative 32-bit divider in the execute stage. It consumes the ALU operation and operands that the decode-to-execute pipeline register presents, and returns a 64-bit {remainder, quotient} result for DIV/DIVU. While a division is in flight it drives a stall request back toward fetch/decode, which freezes the decode-to-execute register. One radix-2 restoring iteration runs per clock.

---
 rtl/cpu_defs_pkg.sv | 17 +
 rtl/ex_div_if.sv | 26 ++
 rtl/ex_div.sv | 159 +++++++++++++++
 tb/tb_ex_div.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared execute-stage definitions: divider FSM states,
// DIV/DIVU aluop codes and the default datapath width.
package cpu_defs_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_if.sv
// Execute <-> divider bundle: request/operands in,
// {rem,quot} result, ready and stall request out.
interface ex_div_if #(
  parameter int WIDTH = 32
);

  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   op1_i;
  logic [WIDTH-1:0]   op2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_o;

  modport master (
    output start_i, annul_i, signed_i, op1_i, op2_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, op1_i, op2_i,
    output result_o, ready_o, stall_o
  );

endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider, one bit per clock.
// Ports: clk, rst (async, high), bus (ex_div_if.slave).
// Signed DIV support only when DIV_SIGNED_EN is defined.
module ex_div
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  // Dividend bits are shifted out of quo_q's top
  // while quotient bits are shifted in at the bottom.
  assign trial  = {rem_q, quo_q[WIDTH-1]};
  assign ge     = trial >= {1'b0, dvs_q};
  assign rem_nx = ge ? (trial[WIDTH-1:0] - dvs_q)
                     : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ge};

`ifdef DIV_SIGNED_EN
  logic neg1_q, neg1_d;
  logic neg2_q, neg2_d;
  logic neg1, neg2;

  assign neg1    = bus.signed_i & bus.op1_i[WIDTH-1];
  assign neg2    = bus.signed_i & bus.op2_i[WIDTH-1];
  assign abs1    = neg1 ? -bus.op1_i : bus.op1_i;
  assign abs2    = neg2 ? -bus.op2_i : bus.op2_i;
  assign quo_fix = (neg1_q ^ neg2_q) ? -quo_nx : quo_nx;
  assign rem_fix = neg1_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
    end else begin
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = bus.signed_i;
  assign abs1    = bus.op1_i;
  assign abs2    = bus.op2_i;
  assign quo_fix = quo_nx;
  assign rem_fix = rem_nx;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
`endif
    case (state_q)
      DIV_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.op2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs1;
            dvs_d   = abs2;
`ifdef DIV_SIGNED_EN
            neg1_d  = neg1;
            neg2_d  = neg2;
`endif
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DIV_END;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end
        end
      end
      DIV_END: begin
        // Held until the stalled EX stage drops start.
        if (!bus.start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.stall_o  = ((state_q == DIV_FREE) && bus.start_i
                         && !bus.annul_i)
                      || (state_q == DIV_ON)
                      || (state_q == DIV_BY_ZERO);

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table with a
// result scoreboard plus annul/reset corner sequences.
module tb_ex_div;
  import cpu_defs_pkg::*;

  localparam int W = 32;

`ifdef DIV_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_div_if #(.WIDTH(W)) bus ();

  ex_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_div(input vec_t v, input string tag);
    int   n;
    int   sc;
    exp_t e;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.signed_i = v.sgn;
    bus.op1_i    = v.a;
    bus.op2_i    = v.b;
    sb.push_back('{v.res, v.lat});
    n  = 0;
    sc = 0;
    #1;
    do begin
      if (bus.stall_o) sc++;
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.op1_i = $urandom;
        bus.op2_i = $urandom;
      end
    end while (!bus.ready_o && n < 100);
    chk({tag, ".ready"}, bus.ready_o, 1);
    e = sb.pop_front();
    chk({tag, ".result"}, bus.result_o, e.res);
    chk({tag, ".latency"}, n, e.lat);
    chk({tag, ".stall_cycles"}, sc, e.lat);
    chk({tag, ".stall_end"}, bus.stall_o, 0);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".hold_ready"}, bus.ready_o, 1);
    chk({tag, ".hold_result"}, bus.result_o, e.res);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".free_ready"}, bus.ready_o, 0);
    chk({tag, ".free_result"}, bus.result_o, 0);
  endtask

  initial begin
    bit seen;
    int n;

    vecs[0] = '{1'b0, 32'd100, 32'd7,
                {32'd2, 32'd14}, 33};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'd1,
                {32'd0, 32'hFFFFFFFF}, 33};
    vecs[2] = '{1'b0, 32'd9, 32'd3,
                {32'd0, 32'd3}, 33};
    vecs[3] = '{1'b0, 32'd5, 32'd0,
                64'd0, 2};
    vecs[4] = '{1'b1, 32'hFFFFFFF9, 32'd2,
                SE ? {32'hFFFFFFFF, 32'hFFFFFFFD}
                   : {32'h00000001, 32'h7FFFFFFC}, 33};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                SE ? {32'h00000000, 32'h80000000}
                   : {32'h80000000, 32'h00000000}, 33};
    vecs[6] = '{1'b1, 32'd7, 32'hFFFFFFFE,
                SE ? {32'h00000001, 32'hFFFFFFFD}
                   : {32'h00000007, 32'h00000000}, 33};
    vecs[7] = '{1'b0, 32'h12345678, 32'h100,
                {32'h78, 32'h00123456}, 33};
    vecs[8] = '{1'b1, 32'h80000000, 32'd0,
                64'd0, 2};
    vecs[9] = '{1'b0, 32'd3, 32'd5,
                {32'd3, 32'd0}, 33};

    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.annul_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    #12;
    chk("reset.ready", bus.ready_o, 0);
    chk("reset.result", bus.result_o, 0);
    chk("reset.stall", bus.stall_o, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_div(vecs[i], $sformatf("vec%0d", i));

    // annul while the request is presented in FREE
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.op1_i   = 32'd50;
    bus.op2_i   = 32'd5;
    #1;
    chk("annul_free.stall", bus.stall_o, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("annul_free.ready", bus.ready_o, 0);
    chk("annul_free.stall2", bus.stall_o, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // annul at iteration 10
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.op1_i    = 32'd1000;
    bus.op2_i    = 32'd3;
    repeat (11) @(posedge clk);
    @(negedge clk);
    #1;
    chk("annul_on.stall_before", bus.stall_o, 1);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_on.stall", bus.stall_o, 0);
    chk("annul_on.ready", bus.ready_o, 0);
    chk("annul_on.result", bus.result_o, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o || bus.stall_o) seen = 1'b1;
    end
    chk("annul_on.quiet", seen, 0);

    // async reset at iteration 20
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op1_i   = 32'hDEAD;
    bus.op2_i   = 32'd7;
    repeat (21) @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    chk("rst_on.stall_before", bus.stall_o, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_on.stall", bus.stall_o, 0);
    chk("rst_on.ready", bus.ready_o, 0);
    chk("rst_on.result", bus.result_o, 0);
    #1;
    rst = 1'b0;
    run_div('{1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33},
            "after_rst");

    // async reset while a result is held in END
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op1_i   = 32'd100;
    bus.op2_i   = 32'd7;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready_o && n < 100);
    chk("rst_end.ready_before", bus.ready_o, 1);
    chk("rst_end.result_before", bus.result_o,
        {32'd2, 32'd14});
    bus.start_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_end.ready", bus.ready_o, 0);
    chk("rst_end.result", bus.result_o, 0);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
